// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Read word returned to a requester whose transaction timed out
  localparam logic [15:0] ERR_RESP = 16'hFFFF;

  // Requester indices, also the spi_sel value that routes SS_n
  localparam int REQ_INERT = 0;
  localparam int REQ_A2D   = 1;

endpackage

// File: rtl/spi_arb_if.sv
// Bundle of requester handshakes and SPI-master signals around the arbiter.
interface spi_arb_if;
  logic        req0;
  logic [15:0] cmd0;
  logic        req1;
  logic [15:0] cmd1;
  logic        done0;
  logic        done1;
  logic        err0;
  logic        err1;
  logic [15:0] resp;
  logic [1:0]  gnt;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_sel;
  logic        spi_done;
  logic [15:0] spi_rd;

  // Arbiter side: serves the requesters and drives the SPI master
  modport slave (
    input  req0, cmd0, req1, cmd1, spi_done, spi_rd,
    output done0, done1, err0, err1, resp, gnt, spi_wrt, spi_cmd, spi_sel
  );

  // Environment side: requesters plus the SPI master
  modport master (
    output req0, cmd0, req1, cmd1, spi_done, spi_rd,
    input  done0, done1, err0, err1, resp, gnt, spi_wrt, spi_cmd, spi_sel
  );
endinterface

// File: rtl/spi_arb_tmr.sv
// Clearable saturating cycle counter; tc flags the last allowed WAIT cycle.
module spi_arb_tmr #(
  parameter int TMO_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int             TW   = $clog2(TMO_CYC);
  localparam logic [TW-1:0]  LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] cnt;

  // Count enabled cycles, holding at the terminal value instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/spi_arb.sv
// Two-requester arbiter in front of a single SPI master (inertial vs A2D).
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int TMO_CYC   = 4096,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  spi_arb_if.slave bus
);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  gnt;
  logic [15:0] spi_cmd;
  logic [15:0] resp;
  logic        spi_sel;
  logic        last;
  logic        tmo;
  logic        any_req;
  logic        win;
  logic        tc;
  logic        tmr_clr;
  logic        tmr_en;
  logic        spi_wrt;
  logic        done0;
  logic        done1;
  logic        err0;
  logic        err1;

  // Pick the winner among the current requests; ties go by priority mode
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = 1'(REQ_INERT);
    if (bus.req0 && bus.req1) begin
      win = FIXED_PRI ? 1'(REQ_INERT) : ~last;
    end else if (bus.req1) begin
      win = 1'(REQ_A2D);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state strobes
  always_comb begin
    state_nxt = state;
    spi_wrt   = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        spi_wrt   = 1'b1;
        tmr_clr   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (bus.spi_done || tc) state_nxt = RESP;
      end
      RESP: begin
        done0     = gnt[0];
        done1     = gnt[1];
        err0      = gnt[0] & tmo;
        err1      = gnt[1] & tmo;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, command routing, response capture and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      spi_cmd <= '0;
      spi_sel <= 1'b0;
      resp    <= '0;
      tmo     <= 1'b0;
      last    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt     <= win ? 2'b10 : 2'b01;
            spi_cmd <= win ? bus.cmd1 : bus.cmd0;
            spi_sel <= win;
          end
        end
        ISSUE: begin
          tmo <= 1'b0;
        end
        WAIT: begin
          // A completion in the terminal cycle still counts as success
          if (bus.spi_done) begin
            resp <= bus.spi_rd;
          end else if (tc) begin
            resp <= ERR_RESP;
            tmo  <= 1'b1;
          end
        end
        RESP: begin
          last <= spi_sel;
          gnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  spi_arb_tmr #(
    .TMO_CYC(TMO_CYC)
  ) u_tmr (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .en (tmr_en),
    .tc (tc)
  );

  assign bus.gnt     = gnt;
  assign bus.spi_cmd = spi_cmd;
  assign bus.spi_sel = spi_sel;
  assign bus.resp    = resp;
  assign bus.spi_wrt = spi_wrt;
  assign bus.done0   = done0;
  assign bus.done1   = done1;
  assign bus.err0    = err0;
  assign bus.err1    = err1;

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: instance 0 is round-robin, instance 1 is fixed priority.
module tb_spi_arb;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        r0 [2];
  logic        r1 [2];
  logic        sd [2];
  logic [15:0] c0 [2];
  logic [15:0] c1 [2];
  logic [15:0] srd [2];
  logic        d0 [2];
  logic        d1 [2];
  logic        e0 [2];
  logic        e1 [2];
  logic        wrt [2];
  logic        ssel [2];
  logic [15:0] rsp [2];
  logic [15:0] scmd [2];
  logic [1:0]  gt [2];

  int checks   = 0;
  int failures = 0;
  int last_srv [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    spi_arb_if bus ();

    spi_arb #(
      .TMO_CYC  (TMO),
      .FIXED_PRI(k == 1)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );

    assign bus.req0     = r0[k];
    assign bus.req1     = r1[k];
    assign bus.cmd0     = c0[k];
    assign bus.cmd1     = c1[k];
    assign bus.spi_done = sd[k];
    assign bus.spi_rd   = srd[k];
    assign d0[k]        = bus.done0;
    assign d1[k]        = bus.done1;
    assign e0[k]        = bus.err0;
    assign e1[k]        = bus.err1;
    assign wrt[k]       = bus.spi_wrt;
    assign ssel[k]      = bus.spi_sel;
    assign rsp[k]       = bus.resp;
    assign scmd[k]      = bus.spi_cmd;
    assign gt[k]        = bus.gnt;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_gnt"}, k, 32'(gt[k]), 0);
      chk({tag, "_cmd"}, k, 32'(scmd[k]), 0);
      chk({tag, "_sel"}, k, 32'(ssel[k]), 0);
      chk({tag, "_resp"}, k, 32'(rsp[k]), 0);
      chk({tag, "_wrt"}, k, 32'(wrt[k]), 0);
      chk({tag, "_done"}, k, {30'd0, d1[k], d0[k]}, 0);
      chk({tag, "_err"}, k, {30'd0, e1[k], e0[k]}, 0);
    end
  endtask

  // One transaction on instance k. lat = WAIT cycle in which the SPI master
  // completes (>= TMO means it never does). exp_lat = negedges from call to spi_wrt.
  task automatic serve(input int k, input int lat, input logic [15:0] rd,
                       input int exp_lat, output int win);
    logic [15:0] ecmd;
    logic [15:0] eresp;
    bit          terr;
    bit          seen;
    int          ewait;
    int          n;
    if (r0[k] && r1[k]) win = (k == 1) ? 0 : 1 - last_srv[k];
    else                win = r1[k] ? 1 : 0;
    ecmd  = (win == 1) ? c1[k] : c0[k];
    terr  = (lat >= TMO);
    eresp = terr ? 16'hFFFF : rd;
    ewait = terr ? TMO : lat + 1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      seen = wrt[k];
    end
    chk("wrt_latency", k, n, exp_lat);
    if (!seen) return;
    chk("issue_sel", k, 32'(ssel[k]), win);
    chk("issue_cmd", k, 32'(scmd[k]), 32'(ecmd));
    chk("issue_gnt", k, 32'(gt[k]), (win == 1) ? 2 : 1);
    if (win == 1) c1[k] = 16'($urandom);
    else          c0[k] = 16'($urandom);
    sd[k] = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < TMO + 8) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("wrt_pulse", k, 32'(wrt[k]), 0);
      seen   = d0[k] | d1[k];
      sd[k]  = !seen && (n - 1 == lat);
      srd[k] = sd[k] ? rd : 16'($urandom);
    end
    sd[k] = 1'b0;
    chk("wait_cycles", k, n - 1, ewait);
    chk("done_vec", k, {30'd0, d1[k], d0[k]}, (win == 1) ? 2 : 1);
    chk("err_vec", k, {30'd0, e1[k], e0[k]}, terr ? ((win == 1) ? 2 : 1) : 0);
    chk("resp", k, 32'(rsp[k]), 32'(eresp));
    chk("resp_sel", k, 32'(ssel[k]), win);
    chk("resp_cmd", k, 32'(scmd[k]), 32'(ecmd));
    chk("resp_gnt", k, 32'(gt[k]), (win == 1) ? 2 : 1);
    last_srv[k] = win;
  endtask

  // Grant must be one-hot or idle, and the two done strobes never coincide
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("gnt_onehot0", k, 32'($onehot0(gt[k])), 1);
      chk("done_excl", k, 32'(d0[k] & d1[k]), 0);
    end
  end

  initial begin
    int w;
    int n;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r0[i] = 1'b0; r1[i] = 1'b0; sd[i] = 1'b0;
      c0[i] = '0;   c1[i] = '0;   srd[i] = '0;
      last_srv[i] = 1;
    end
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    // spi_done while idle is ignored
    sd[0] = 1'b1; srd[0] = 16'hBEEF;
    @(negedge clk);
    sd[0] = 1'b0;
    chk("stray_done", 0, {30'd0, d1[0], d0[0]}, 0);
    chk("stray_resp", 0, 32'(rsp[0]), 0);
    chk("stray_gnt", 0, 32'(gt[0]), 0);

    // Basic requester-0 transaction
    r0[0] = 1'b1; c0[0] = 16'hA5A5;
    serve(0, 3, 16'h1234, 1, w);
    r0[0] = 1'b0;
    @(negedge clk);
    chk("idle_gnt", 0, 32'(gt[0]), 0);

    // Round-robin with both requests held
    r0[0] = 1'b1; r1[0] = 1'b1;
    c0[0] = 16'($urandom); c1[0] = 16'($urandom);
    for (int i = 0; i < 4; i++) serve(0, $urandom_range(0, 5), 16'($urandom), (i == 0) ? 1 : 2, w);
    r0[0] = 1'b0; r1[0] = 1'b0;

    // Fixed priority with both requests held, then requester 0 drops
    @(negedge clk);
    r0[1] = 1'b1; r1[1] = 1'b1;
    c0[1] = 16'($urandom); c1[1] = 16'($urandom);
    for (int i = 0; i < 3; i++) serve(1, $urandom_range(0, 5), 16'($urandom), (i == 0) ? 1 : 2, w);
    r0[1] = 1'b0;
    serve(1, 2, 16'($urandom), 2, w);
    r1[1] = 1'b0;

    // Timeout on requester 1, then a normal requester-0 transaction
    @(negedge clk);
    r1[0] = 1'b1; c1[0] = 16'h0F0F;
    serve(0, TMO + 4, 16'h5555, 1, w);
    r1[0] = 1'b0; r0[0] = 1'b1; c0[0] = 16'h3C3C;
    serve(0, 2, 16'h7E81, 2, w);

    // Completion in the exact timeout cycle wins over the timeout
    serve(0, TMO - 1, 16'h6A6A, 2, w);
    r0[0] = 1'b0;

    // Reset during WAIT abandons the transaction and restores the pointer
    @(negedge clk);
    r0[0] = 1'b1;
    serve(0, 1, 16'h1111, 1, w);
    n = 0;
    while (!wrt[0] && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("abort_issue", 0, 32'(wrt[0]), 1);
    repeat (3) @(negedge clk);
    r1[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    last_srv[0] = 1; last_srv[1] = 1;
    @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;
    serve(0, 4, 16'h2222, 1, w);
    r0[0] = 1'b0;
    serve(0, 3, 16'h3333, 2, w);
    r1[0] = 1'b0;

    // Randomized transactions on either instance
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      k = $urandom_range(0, 1);
      r0[k] = 1'($urandom_range(0, 1));
      r1[k] = r0[k] ? 1'($urandom_range(0, 1)) : 1'b1;
      c0[k] = 16'($urandom); c1[k] = 16'($urandom);
      serve(k, $urandom_range(0, TMO + 2), 16'($urandom), 1, w);
      r0[k] = 1'b0; r1[k] = 1'b0;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_arb.md
Name: spi_arb

Overview:
- Shares one SPI transaction engine (a single SPI master with its SS_n/SCLK/MOSI/MISO) between two requesters: the inertial interface (requester 0) and the A2D interface (requester 1).
- Arbitrates one 16-bit transaction at a time and routes the slave select to the granted device.
- Returns the read word to the granted requester.
- Guards against a hung master with a timeout.
- Sits between inert_intf/A2D_intf and the SPI master at the Segway top level.

Parameters:
- TMO_CYC, 4096, cycles allowed in WAIT before a transaction is aborted (minimum 4).
- FIXED_PRI, 0, 1 = requester 0 always wins ties; 0 = round-robin.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req0  in  1  requester 0 transaction request, level, held until done0
- cmd0  in  16  requester 0 command word, stable while req0 high
- req1  in  1  requester 1 transaction request, level, held until done1
- cmd1  in  16  requester 1 command word, stable while req1 high
- done0  out  1  one-cycle pulse, requester 0 transaction finished
- done1  out  1  one-cycle pulse, requester 1 transaction finished
- err0  out  1  one-cycle pulse coincident with done0 when the transaction timed out
- err1  out  1  same, requester 1
- resp  out  16  read data, valid in the cycle done0 or done1 is high
- gnt  out  2  one-hot current grant, 00 when idle
- spi_wrt  out  1  one-cycle start pulse to the SPI master
- spi_cmd  out  16  command to the SPI master, registered
- spi_sel  out  1  SS routing select (0 = inertial, 1 = A2D), registered
- spi_done  in  1  SPI master transaction complete pulse
- spi_rd  in  16  SPI master read data, valid with spi_done

Behaviour:
- Reset (async, rst=1) forces these values:
  - state=IDLE, gnt=00
  - done0/1=0, err0/1=0, spi_wrt=0
  - spi_cmd=0, spi_sel=0, resp=0, timer=0
  - last-served pointer=1, so requester 0 is preferred first.
- Asserting rst mid-transaction abandons it. No done/err pulse is issued. The requester must restart.
- IDLE:
  - Sample req0/req1.
  - If only one is high, grant it.
  - If both are high:
    - FIXED_PRI=1: grant requester 0.
    - FIXED_PRI=0: grant the requester not equal to the last-served pointer.
  - On a grant, register gnt, spi_cmd=cmd of the winner, spi_sel=winner index. Go to ISSUE.
  - If no request, stay in IDLE with gnt=00.
- ISSUE (1 cycle):
  - spi_wrt=1. Clear the timer. Go to WAIT.
  - Latency is req seen in IDLE (cycle N) → spi_wrt high in cycle N+1.
- WAIT:
  - Timer increments each cycle. spi_wrt=0.
  - spi_done=1: capture resp<=spi_rd and go to RESP.
  - Otherwise, if timer==TMO_CYC-1: set resp<=16'hFFFF, flag the error, and go to RESP.
  - spi_done and the timeout in the same cycle: spi_done wins, no error.
- RESP (1 cycle):
  - done of the granted requester=1.
  - err of the granted requester=1 only if a timeout occurred.
  - Update the last-served pointer to the granted index.
  - Then gnt<=00 and go to IDLE.
- Handshake rules:
  - A requester registers done and drops req by the cycle after done. IDLE in that cycle therefore sees the updated req.
  - A req held beyond that cycle is served again. This is legal.
  - cmd changes while req is high are ignored after IDLE latches spi_cmd.
- spi_done outside WAIT is ignored.
- gnt is one-hot or 00 at all times. done0/done1 are never high together.
- spi_cmd and spi_sel are held constant from ISSUE through RESP.
- Timer width is clog2(TMO_CYC). The timer saturates and does not wrap. It is cleared in ISSUE.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - ERR_RESP=16'hFFFF
  - localparams REQ_INERT=0 and REQ_A2D=1
- The only sub-module is spi_arb_tmr: a clearable, saturating timeout counter with a terminal-count output. Arbitration and the FSM stay in spi_arb.

Test Plan:
1. Reset, then req0=1, cmd0=16'hA5A5 → spi_wrt pulses 1 cycle after req is seen, spi_sel=0, spi_cmd=A5A5. Then spi_done with spi_rd=16'h1234 → done0 one cycle later with resp=1234, err0=0, gnt returns to 00.
2. FIXED_PRI=0, req0 and req1 both held continuously → grants alternate 0,1,0,1 over 4 transactions. spi_sel matches each grant and gnt is never 11.
3. FIXED_PRI=1, both requests held → requester 0 is granted every time. Requester 1 is served only once req0 drops.
4. req1, spi_done never returned, TMO_CYC=16 → exactly 16 WAIT cycles, then done1 and err1 pulse together with resp=FFFF. A following req0 is served normally.
5. spi_done arrives in the exact timeout cycle → err=0 and resp=spi_rd.
6. rst asserted during WAIT → all outputs return to reset values immediately (async), with no done pulse. After release, a pending req0 is granted first.
